// File: rtl/scan_mux_pkg.sv
// ============================================================================
// Module   : scan_mux_pkg
// Brief    : Shared state encoding and select-width helper for scan_mux.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package scan_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    // Select width never collapses below one bit, even for tiny NCH.
    function automatic int sel_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_mux_ptr.sv
// ============================================================================
// Module   : scan_mux_ptr
// Brief    : Channel pointer with direct load, increment-with-wrap and a
//            one-cycle wrap pulse.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module scan_mux_ptr #(
    parameter int NCH = 16,
    parameter int SW  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld,
    input  logic [SW-1:0] ld_val,
    input  logic          inc,
    output logic [SW-1:0] ptr,
    output logic          wrap
);

    localparam logic [SW-1:0] c_last = SW'(NCH - 1);

    logic [SW-1:0] r_ptr;
    logic          r_wrap;
    logic          w_at_last;

    assign w_at_last = (r_ptr == c_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= '0;
            r_wrap <= 1'b0;
        end else begin
            // A load always beats an increment, so no wrap is reported then.
            r_wrap <= inc && !ld && w_at_last;
            if (ld)
                r_ptr <= ld_val;
            else if (inc)
                r_ptr <= w_at_last ? '0 : r_ptr + 1'b1;
        end
    end

    assign ptr  = r_ptr;
    assign wrap = r_wrap;

endmodule

`default_nettype wire

// File: rtl/scan_mux.sv
// ============================================================================
// Module   : scan_mux
// Brief    : NCH-channel sampling multiplexer with hold / auto-scan modes and
//            a valid/ready registered output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int  NCH = 16,
    parameter int  W   = 1,
    localparam int SW  = sel_width(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH*W-1:0] din,
    input  logic [SW-1:0]  sel,
    input  logic           sel_ld,
    input  logic           scan_en,
    input  logic           stop,
    input  logic           force_hi,
    input  logic           out_ready,
    output logic           out_valid,
    output logic [W-1:0]   dout,
    output logic [SW-1:0]  chan_out,
    output logic           wrap,
    output logic           sel_err
);

    localparam logic [SW:0] c_nch = (SW + 1)'(NCH);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [SW-1:0] w_ptr;
    logic          w_sel_ok;
    logic          w_ld_ok;
    logic          w_xfer;
    logic          w_inc;
    logic [W-1:0]  w_chans [NCH];
    logic          r_out_valid;
    logic [W-1:0]  r_dout;
    logic [SW-1:0] r_chan_out;
    logic          r_sel_err;

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        assign w_chans[k] = din[k*W +: W];
    end

    assign w_sel_ok = ({1'b0, sel} < c_nch);
    assign w_ld_ok  = sel_ld && w_sel_ok;
    assign w_xfer   = (r_state != ST_IDLE) && (!r_out_valid || out_ready);
    // stop keeps the pointer, and a valid load overrides the scan step.
    assign w_inc    = (r_state == ST_SCAN) && w_xfer && !stop && !w_ld_ok;

    scan_mux_ptr #(
        .NCH (NCH),
        .SW  (SW)
    ) u_ptr (
        .clk    (clk),
        .rst    (rst),
        .ld     (w_ld_ok && !stop),
        .ld_val (sel),
        .inc    (w_inc),
        .ptr    (w_ptr),
        .wrap   (wrap)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (stop)
            w_state_nxt = ST_IDLE;
        else if (w_ld_ok)
            w_state_nxt = scan_en ? ST_SCAN : ST_HOLD;
        else if (scan_en)
            w_state_nxt = ST_SCAN;
        else if (r_state != ST_IDLE)
            w_state_nxt = ST_HOLD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_chan_out  <= '0;
            r_sel_err   <= 1'b0;
        end else begin
            r_sel_err <= sel_ld && !w_sel_ok;
            if (stop) begin
                r_out_valid <= 1'b0;
            end else if (w_xfer) begin
                r_dout      <= force_hi ? {W{1'b1}} : w_chans[w_ptr];
                r_chan_out  <= w_ptr;
                r_out_valid <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign dout      = r_dout;
    assign chan_out  = r_chan_out;
    assign sel_err   = r_sel_err;

endmodule

`default_nettype wire

// File: tb/tb_scan_mux.sv
// ============================================================================
// Module   : tb_scan_mux
// Brief    : Directed self-checking bench for scan_mux (NCH=16 and NCH=12).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_scan_mux;

    logic clk;
    logic rst;

    // Instance A: NCH=16, W=8
    logic [127:0] a_din;
    logic [3:0]   a_sel;
    logic         a_sel_ld, a_scan_en, a_stop, a_force_hi, a_out_ready;
    logic         a_out_valid, a_wrap, a_sel_err;
    logic [7:0]   a_dout;
    logic [3:0]   a_chan_out;

    // Instance B: NCH=12, W=8
    logic [95:0]  b_din;
    logic [3:0]   b_sel;
    logic         b_sel_ld, b_scan_en, b_stop, b_force_hi, b_out_ready;
    logic         b_out_valid, b_wrap, b_sel_err;
    logic [7:0]   b_dout;
    logic [3:0]   b_chan_out;

    int checks = 0;
    int errors = 0;

    scan_mux #(.NCH(16), .W(8)) dut_a (
        .clk(clk), .rst(rst), .din(a_din), .sel(a_sel), .sel_ld(a_sel_ld),
        .scan_en(a_scan_en), .stop(a_stop), .force_hi(a_force_hi),
        .out_ready(a_out_ready), .out_valid(a_out_valid), .dout(a_dout),
        .chan_out(a_chan_out), .wrap(a_wrap), .sel_err(a_sel_err)
    );

    scan_mux #(.NCH(12), .W(8)) dut_b (
        .clk(clk), .rst(rst), .din(b_din), .sel(b_sel), .sel_ld(b_sel_ld),
        .scan_en(b_scan_en), .stop(b_stop), .force_hi(b_force_hi),
        .out_ready(b_out_ready), .out_valid(b_out_valid), .dout(b_dout),
        .chan_out(b_chan_out), .wrap(b_wrap), .sel_err(b_sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) a_din[k*8 +: 8] = 8'h10 + 8'(k);
        for (int k = 0; k < 12; k++) b_din[k*8 +: 8] = 8'h20 + 8'(k);
        a_sel = '0; a_sel_ld = 0; a_scan_en = 0; a_stop = 0; a_force_hi = 0; a_out_ready = 1;
        b_sel = '0; b_sel_ld = 0; b_scan_en = 0; b_stop = 0; b_force_hi = 0; b_out_ready = 1;
        rst = 0;
        #1 rst = 1;
        #1;
        chk("rst_valid", {31'd0, a_out_valid}, 0);
        chk("rst_dout",  {24'd0, a_dout}, 0);
        chk("rst_chan",  {28'd0, a_chan_out}, 0);
        chk("rst_wrap",  {31'd0, a_wrap}, 0);
        chk("rst_err",   {31'd0, a_sel_err}, 0);
        step();
        rst = 0;

        // Hold on channel 5
        a_sel = 4'd5; a_sel_ld = 1;
        step();
        a_sel_ld = 0;
        chk("hold_nov", {31'd0, a_out_valid}, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_dout", {24'd0, a_dout}, 32'h15);
            chk("hold_chan", {28'd0, a_chan_out}, 5);
            chk("hold_valid", {31'd0, a_out_valid}, 1);
            chk("hold_wrap", {31'd0, a_wrap}, 0);
        end

        // Scan from 14 across the wrap
        a_sel = 4'd14; a_sel_ld = 1; a_scan_en = 1;
        step();
        a_sel_ld = 0;
        chk("ld_oldptr", {28'd0, a_chan_out}, 5);
        step(); chk("scan14", {28'd0, a_chan_out}, 14); chk("w14", {31'd0, a_wrap}, 0);
        step(); chk("scan15", {28'd0, a_chan_out}, 15); chk("w15", {31'd0, a_wrap}, 1);
        step(); chk("scan0",  {28'd0, a_chan_out}, 0);  chk("w0",  {31'd0, a_wrap}, 0);
        step(); chk("scan1",  {28'd0, a_chan_out}, 1);  chk("w1",  {31'd0, a_wrap}, 0);
        chk("scan1_dout", {24'd0, a_dout}, 32'h11);

        // Backpressure freezes output and pointer
        a_out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_chan", {28'd0, a_chan_out}, 1);
            chk("bp_dout", {24'd0, a_dout}, 32'h11);
        end
        a_out_ready = 1;
        step(); chk("bp_resume", {28'd0, a_chan_out}, 2);

        // Drop to HOLD, then force_hi
        a_scan_en = 0;
        step(); chk("to_hold", {28'd0, a_chan_out}, 3);
        a_force_hi = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("fh_dout", {24'd0, a_dout}, 32'hFF);
            chk("fh_chan", {28'd0, a_chan_out}, 4);
        end
        a_force_hi = 0;

        // stop + sel_ld while output stalled
        a_out_ready = 0; a_stop = 1; a_sel_ld = 1; a_sel = 4'd9;
        step();
        a_stop = 0; a_sel_ld = 0; a_out_ready = 1;
        chk("stop_nov", {31'd0, a_out_valid}, 0);
        step(); chk("idle_nov", {31'd0, a_out_valid}, 0);
        a_scan_en = 1;
        step(); chk("idle2scan", {31'd0, a_out_valid}, 0);
        step(); chk("stop_ptrkept", {28'd0, a_chan_out}, 4);
        step(); chk("scan_again", {28'd0, a_chan_out}, 5);

        // Asynchronous reset mid-scan
        #2 rst = 1;
        #1;
        chk("arst_valid", {31'd0, a_out_valid}, 0);
        chk("arst_dout",  {24'd0, a_dout}, 0);
        chk("arst_chan",  {28'd0, a_chan_out}, 0);
        a_scan_en = 0;
        step();
        rst = 0;

        // NCH=12: invalid select, then wrap from 11
        b_sel = 4'd11; b_sel_ld = 1;
        step();
        b_sel = 4'd13;
        step();
        b_sel_ld = 0;
        chk("b_err", {31'd0, b_sel_err}, 1);
        chk("b_chan11", {28'd0, b_chan_out}, 11);
        step();
        chk("b_err_pulse", {31'd0, b_sel_err}, 0);
        chk("b_ptr_kept", {28'd0, b_chan_out}, 11);
        b_scan_en = 1;
        step(); chk("b_hold2scan", {28'd0, b_chan_out}, 11);
        step(); chk("b_scan11", {28'd0, b_chan_out}, 11); chk("b_wrap", {31'd0, b_wrap}, 1);
        step(); chk("b_scan0", {28'd0, b_chan_out}, 0); chk("b_wrap_off", {31'd0, b_wrap}, 0);
        chk("b_dout0", {24'd0, b_dout}, 32'h20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
